ddr_20g_chk_ctrl: RTL

Run controller for the DDR 20G readback checker path (parser plus ADC/encoder checkers). On a software start it clears the checkers and opens a gated measurement window on the 256-bit readback stream. The window is bounded by beat count, software stop or inactivity timeout. At the end it drains the checker pipeline, snapshots the four checker counters and reports pass/fail. It sits between the DDR readback stream and the checker top, and drives the checker's cfg_rst.

---
 rtl/ddr_chk_pkg.sv | 16 +
 rtl/ddr_chk_gate.sv | 56 +++++
 rtl/ddr_20g_chk_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_chk_pkg.sv
// Shared definitions for the DDR 20G readback checker path: run-controller
// state encoding and the packet end marker used by the checkers.
package ddr_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SNAP  = 3'd4,
        ST_DONE  = 3'd5
    } chk_state_e;

    localparam logic [127:0] PKT_END_FLAG = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

endpackage

// File: rtl/ddr_chk_gate.sv
// Registered valid/data gate between the readback stream and the checker,
// with a saturating count of forwarded beats.
module ddr_chk_gate
    import ddr_chk_pkg::*;
#(
    parameter int DATA_WD = 256,
    parameter int CNT_WD  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cnt_clr,
    input  logic [DATA_WD-1:0] s_tdata,
    input  logic               s_tvalid,
    output logic [DATA_WD-1:0] m_tdata,
    output logic               m_tvalid,
    output logic [CNT_WD-1:0]  beat_cnt
);

    logic [DATA_WD-1:0] m_tdata_q, m_tdata_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic [CNT_WD-1:0]  beat_cnt_q, beat_cnt_d;
    logic               fwd;

    always_comb begin
        fwd        = en & s_tvalid;
        m_tvalid_d = fwd;
        m_tdata_d  = m_tdata_q;
        beat_cnt_d = beat_cnt_q;
        if (fwd) begin
            m_tdata_d = s_tdata;
        end
        if (cnt_clr) begin
            beat_cnt_d = '0;
        end else if (fwd && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: rtl/ddr_20g_chk_ctrl.sv
// Run controller for the DDR 20G readback checker: clears the checkers, opens a
// bounded measurement window, drains the pipeline and snapshots the counters.
module ddr_20g_chk_ctrl
    import ddr_chk_pkg::*;
#(
    parameter int DATA_WD      = 256,
    parameter int CNT_WD       = 32,
    parameter int CLR_CYCLES   = 16,
    parameter int DRAIN_CYCLES = 8,
    parameter int TO_WD        = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    input  logic [CNT_WD-1:0]  cfg_run_len,
    input  logic [TO_WD-1:0]   cfg_timeout,
    input  logic [DATA_WD-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic [DATA_WD-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               chk_rst,
    input  logic [CNT_WD-1:0]  adc_suc_cnt,
    input  logic [CNT_WD-1:0]  adc_err_cnt,
    input  logic [CNT_WD-1:0]  enc_suc_cnt,
    input  logic [CNT_WD-1:0]  enc_err_cnt,
    output logic [CNT_WD-1:0]  snap_adc_suc,
    output logic [CNT_WD-1:0]  snap_adc_err,
    output logic [CNT_WD-1:0]  snap_enc_suc,
    output logic [CNT_WD-1:0]  snap_enc_err,
    output logic [CNT_WD-1:0]  beat_cnt,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout_flag,
    output logic [2:0]         state
);

    localparam logic [15:0] CLR_LAST   = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    chk_state_e         state_q, state_d;
    logic [15:0]        tmr_q, tmr_d;
    logic [TO_WD-1:0]   idle_q, idle_d;
    logic [CNT_WD-1:0]  run_len_q, run_len_d;
    logic [TO_WD-1:0]   timeout_q, timeout_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic [CNT_WD-1:0]  snap_adc_suc_q, snap_adc_suc_d;
    logic [CNT_WD-1:0]  snap_adc_err_q, snap_adc_err_d;
    logic [CNT_WD-1:0]  snap_enc_suc_q, snap_enc_suc_d;
    logic [CNT_WD-1:0]  snap_enc_err_q, snap_enc_err_d;

    logic               gate_en;
    logic               cnt_clr;
    logic               last_beat;
    logic               to_hit;

    ddr_chk_gate #(
        .DATA_WD (DATA_WD),
        .CNT_WD  (CNT_WD)
    ) u_gate (
        .clk      (clk),
        .rst      (rst),
        .en       (gate_en),
        .cnt_clr  (cnt_clr),
        .s_tdata  (s_axis_tdata),
        .s_tvalid (s_axis_tvalid),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .beat_cnt (beat_cnt)
    );

    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        idle_d         = idle_q;
        run_len_d      = run_len_q;
        timeout_d      = timeout_q;
        timeout_flag_d = timeout_flag_q;
        pass_d         = pass_q;
        done_d         = 1'b0;
        snap_adc_suc_d = snap_adc_suc_q;
        snap_adc_err_d = snap_adc_err_q;
        snap_enc_suc_d = snap_enc_suc_q;
        snap_enc_err_d = snap_enc_err_q;
        gate_en        = 1'b0;
        cnt_clr        = 1'b0;
        // The beat that reaches run_len is the one being forwarded this cycle.
        last_beat      = (run_len_q != '0) && s_axis_tvalid &&
                         ((beat_cnt + CNT_WD'(1)) == run_len_q);
        to_hit         = (timeout_q != '0) && !s_axis_tvalid &&
                         ((idle_q + TO_WD'(1)) == timeout_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    state_d        = ST_CLEAR;
                    tmr_d          = '0;
                    cnt_clr        = 1'b1;
                    pass_d         = 1'b0;
                    timeout_flag_d = 1'b0;
                    run_len_d      = cfg_run_len;
                    timeout_d      = cfg_timeout;
                end
            end
            ST_CLEAR: begin
                idle_d = '0;
                if (tmr_q == CLR_LAST) begin
                    state_d = ST_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_RUN: begin
                gate_en = 1'b1;
                idle_d  = s_axis_tvalid ? '0 : idle_q + TO_WD'(1);
                if (to_hit) begin
                    timeout_flag_d = 1'b1;
                end
                if (last_beat || cfg_stop || to_hit) begin
                    state_d = ST_DRAIN;
                    tmr_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (tmr_q == DRAIN_LAST) begin
                    state_d = ST_SNAP;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_SNAP: begin
                snap_adc_suc_d = adc_suc_cnt;
                snap_adc_err_d = adc_err_cnt;
                snap_enc_suc_d = enc_suc_cnt;
                snap_enc_err_d = enc_err_cnt;
                pass_d  = (adc_err_cnt == '0) && (enc_err_cnt == '0) &&
                          (adc_suc_cnt != '0) && !timeout_flag_q;
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tmr_q          <= '0;
            idle_q         <= '0;
            run_len_q      <= '0;
            timeout_q      <= '0;
            timeout_flag_q <= 1'b0;
            pass_q         <= 1'b0;
            done_q         <= 1'b0;
            snap_adc_suc_q <= '0;
            snap_adc_err_q <= '0;
            snap_enc_suc_q <= '0;
            snap_enc_err_q <= '0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            idle_q         <= idle_d;
            run_len_q      <= run_len_d;
            timeout_q      <= timeout_d;
            timeout_flag_q <= timeout_flag_d;
            pass_q         <= pass_d;
            done_q         <= done_d;
            snap_adc_suc_q <= snap_adc_suc_d;
            snap_adc_err_q <= snap_adc_err_d;
            snap_enc_suc_q <= snap_enc_suc_d;
            snap_enc_err_q <= snap_enc_err_d;
        end
    end

    // Checkers stay in reset from power-up until the first run leaves CLEAR.
    assign chk_rst      = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign busy         = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                          (state_q == ST_DRAIN) || (state_q == ST_SNAP);
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout_flag = timeout_flag_q;
    assign state        = state_q;
    assign snap_adc_suc = snap_adc_suc_q;
    assign snap_adc_err = snap_adc_err_q;
    assign snap_enc_suc = snap_enc_suc_q;
    assign snap_enc_err = snap_enc_err_q;

endmodule
